// File: rtl/fetch_stage_pkg.sv
// Shared definitions for the fetch stage: widths, reset PC, FSM states and
// the RV32 opcode constants used by the control unit and benches.
package fetch_stage_pkg;

  localparam int              XLEN     = 32;
  localparam logic [XLEN-1:0] RESET_PC = 32'h0000_0000;

  typedef enum logic [1:0] {
    REQ,
    WAIT,
    DROP,
    FULL
  } fetch_state_t;

  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_REG    = 7'b0110011;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;

endpackage

// File: rtl/fetch_stage_if.sv
// Bundle of the fetch stage's memory handshake, decode-side controls and
// decode-side outputs. master = fetch stage, slave = memory/decode side.
interface fetch_stage_if #(
  parameter int XLEN = fetch_stage_pkg::XLEN
);
  logic            imem_req;
  logic [XLEN-1:0] imem_addr;
  logic            imem_rvalid;
  logic [31:0]     imem_rdata;
  logic            stall;
  logic            redirect_valid;
  logic [XLEN-1:0] redirect_pc;
  logic            if_valid;
  logic [XLEN-1:0] if_pc;
  logic [31:0]     if_instr;
  logic [6:0]      if_opcode;

  modport master (
    output imem_req, imem_addr, if_valid, if_pc, if_instr, if_opcode,
    input  imem_rvalid, imem_rdata, stall, redirect_valid, redirect_pc
  );

  modport slave (
    input  imem_req, imem_addr, if_valid, if_pc, if_instr, if_opcode,
    output imem_rvalid, imem_rdata, stall, redirect_valid, redirect_pc
  );
endinterface

// File: rtl/fetch_skid_buf.sv
// Two-entry instruction buffer: the output register seen by decode plus one
// skid entry that catches a response arriving while decode is stalled.
module fetch_skid_buf #(
  parameter int XLEN = fetch_stage_pkg::XLEN
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            push,
  input  logic [XLEN-1:0] push_pc,
  input  logic [31:0]     push_instr,
  input  logic            pop,
  input  logic            flush,
  output logic            empty,
  output logic            full,
  output logic            full_next,
  output logic [XLEN-1:0] out_pc,
  output logic [31:0]     out_instr
);
  import fetch_stage_pkg::*;

  logic            out_valid, out_valid_n;
  logic [XLEN-1:0] out_pc_n;
  logic [31:0]     out_instr_n;
  logic            skid_valid, skid_valid_n;
  logic [XLEN-1:0] skid_pc, skid_pc_n;
  logic [31:0]     skid_instr, skid_instr_n;
  logic            take;

  assign take = pop && out_valid;

  // A push lands in the output slot whenever that slot is free after this
  // cycle's pop; only otherwise does it go to the skid entry.
  always_comb begin
    out_valid_n  = out_valid;
    out_pc_n     = out_pc;
    out_instr_n  = out_instr;
    skid_valid_n = skid_valid;
    skid_pc_n    = skid_pc;
    skid_instr_n = skid_instr;
    if (flush) begin
      out_valid_n  = 1'b0;
      skid_valid_n = 1'b0;
    end else begin
      if (take) begin
        out_valid_n  = skid_valid;
        skid_valid_n = 1'b0;
        if (skid_valid) begin
          out_pc_n    = skid_pc;
          out_instr_n = skid_instr;
        end
      end
      if (push) begin
        if (!out_valid_n) begin
          out_valid_n = 1'b1;
          out_pc_n    = push_pc;
          out_instr_n = push_instr;
        end else begin
          skid_valid_n = 1'b1;
          skid_pc_n    = push_pc;
          skid_instr_n = push_instr;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid  <= 1'b0;
      out_pc     <= '0;
      out_instr  <= '0;
      skid_valid <= 1'b0;
      skid_pc    <= '0;
      skid_instr <= '0;
    end else begin
      out_valid  <= out_valid_n;
      out_pc     <= out_pc_n;
      out_instr  <= out_instr_n;
      skid_valid <= skid_valid_n;
      skid_pc    <= skid_pc_n;
      skid_instr <= skid_instr_n;
    end
  end

  assign empty     = !out_valid;
  assign full      = skid_valid;
  assign full_next = skid_valid_n;

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch stage: PC register, single-outstanding memory request
// FSM, redirect handling, and the buffered {pc, instr, opcode} to decode.
module fetch_stage #(
  parameter int              XLEN     = fetch_stage_pkg::XLEN,
  parameter logic [XLEN-1:0] RESET_PC = fetch_stage_pkg::RESET_PC
) (
  input  logic          clk,
  input  logic          rst,
  fetch_stage_if.master bus
);
  import fetch_stage_pkg::*;

  fetch_state_t    state, state_next;
  logic [XLEN-1:0] pc, pc_next;
  logic [XLEN-1:0] req_pc, req_pc_next;
  logic            push, pop, flush;
  logic            buf_empty, skid_full, skid_full_next;
  logic [XLEN-1:0] out_pc;
  logic [31:0]     out_instr;

  assign bus.imem_req  = (state == REQ) && !rst;
  assign bus.imem_addr = pc;

  assign pop   = !buf_empty && !bus.stall;
  assign flush = bus.redirect_valid;
  assign push  = (state == WAIT) && bus.imem_rvalid && !bus.redirect_valid;

  fetch_skid_buf #(.XLEN(XLEN)) u_buf (
    .clk        (clk),
    .rst        (rst),
    .push       (push),
    .push_pc    (req_pc),
    .push_instr (bus.imem_rdata),
    .pop        (pop),
    .flush      (flush),
    .empty      (buf_empty),
    .full       (skid_full),
    .full_next  (skid_full_next),
    .out_pc     (out_pc),
    .out_instr  (out_instr)
  );

  // A redirect overrides the normal transition; whatever request is still
  // in flight at that point must be waited out in DROP and discarded.
  always_comb begin
    state_next  = state;
    pc_next     = pc;
    req_pc_next = req_pc;
    case (state)
      REQ: begin
        req_pc_next = pc;
        pc_next     = pc + XLEN'(4);
        state_next  = WAIT;
      end
      WAIT: if (bus.imem_rvalid) state_next = skid_full_next ? FULL : REQ;
      DROP: if (bus.imem_rvalid) state_next = REQ;
      FULL: if (pop) state_next = REQ;
      default: state_next = REQ;
    endcase
    if (bus.redirect_valid) begin
      pc_next = bus.redirect_pc;
      case (state)
        REQ:     state_next = DROP;
        WAIT:    state_next = bus.imem_rvalid ? REQ : DROP;
        DROP:    state_next = bus.imem_rvalid ? REQ : DROP;
        default: state_next = REQ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= REQ;
      pc     <= RESET_PC;
      req_pc <= RESET_PC;
    end else begin
      state  <= state_next;
      pc     <= pc_next;
      req_pc <= req_pc_next;
    end
  end

  assign bus.if_valid  = !buf_empty;
  assign bus.if_pc     = out_pc;
  assign bus.if_instr  = out_instr;
  assign bus.if_opcode = out_instr[6:0];

`ifndef SYNTHESIS
  // Memory must only answer while a request is outstanding.
  a_rvalid_expected: assert property (@(posedge clk) disable iff (rst)
    bus.imem_rvalid |-> (state == WAIT || state == DROP));
  a_no_overflow: assert property (@(posedge clk) disable iff (rst)
    push |-> !skid_full);
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: directed scenarios with literal expectations plus a
// transaction-level model (expected PC stream and queue of fetched entries).
module tb_fetch_stage;
  import fetch_stage_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  fetch_stage_if #(.XLEN(32)) bus ();

  fetch_stage #(.XLEN(32), .RESET_PC(32'h0000_0000)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks = 0;
  int passes = 0;

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual === expected) passes++;
    else $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
  endtask

  // Instruction memory: one request at a time, answers mem_lat cycles later.
  int          mem_lat   = 1;
  bit          mem_const = 1'b1;
  bit          mem_busy  = 1'b0;
  int          mem_cnt   = 0;
  logic [31:0] mem_addr  = '0;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    logic [31:0] w;
    w = mem_const ? 32'h0000_0033 : {a[24:0], OP_REG};
    return w;
  endfunction

  initial begin
    bus.imem_rvalid = 1'b0;
    bus.imem_rdata  = '0;
    forever begin
      @(negedge clk);
      if (bus.imem_req && !rst && !mem_busy) begin
        mem_busy = 1'b1;
        mem_addr = bus.imem_addr;
        mem_cnt  = mem_lat;
      end
      @(posedge clk);
      #1;
      bus.imem_rvalid = 1'b0;
      if (mem_busy) begin
        if (mem_cnt <= 1) begin
          bus.imem_rvalid = 1'b1;
          bus.imem_rdata  = mem_word(mem_addr);
          mem_busy        = 1'b0;
        end else begin
          mem_cnt--;
        end
      end
    end
  end

  // Model: expected fetch address, one outstanding request, and the queue of
  // instructions decode should see in order. Redirects empty the queue and
  // kill any in-flight response.
  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
  } ent_t;

  ent_t        q[$];
  logic [31:0] m_pc       = 32'h0;
  logic [31:0] m_req_addr = 32'h0;
  bit          m_out      = 1'b0;
  bit          m_killed   = 1'b0;

  initial begin
    forever begin
      @(negedge clk);
      checkOutput("m_if_valid", bus.if_valid, (q.size() != 0));
      if (q.size() != 0) begin
        checkOutput("m_if_pc", bus.if_pc, q[0].pc);
        checkOutput("m_if_instr", bus.if_instr, q[0].instr);
        checkOutput("m_if_opcode", bus.if_opcode, q[0].instr[6:0]);
      end
      if (rst) checkOutput("m_req_in_reset", bus.imem_req, 1'b0);
      if (bus.imem_req) begin
        checkOutput("m_imem_addr", bus.imem_addr, m_pc);
        checkOutput("m_single_outstanding", m_out, 1'b0);
        checkOutput("m_room_for_response", (q.size() < 2), 1'b1);
      end

      if (rst) begin
        q.delete();
        m_pc     = RESET_PC;
        m_out    = 1'b0;
        m_killed = 1'b0;
      end else begin
        bit   do_push;
        ent_t e;
        do_push = 1'b0;
        if (bus.imem_rvalid && m_out) begin
          do_push = !m_killed && !bus.redirect_valid;
          e.pc    = m_req_addr;
          e.instr = mem_word(m_req_addr);
          m_out   = 1'b0;
        end
        if (bus.if_valid && !bus.stall && !bus.redirect_valid && q.size() != 0)
          void'(q.pop_front());
        if (do_push) q.push_back(e);
        if (bus.imem_req) begin
          m_out      = 1'b1;
          m_killed   = 1'b0;
          m_req_addr = m_pc;
          m_pc       = m_pc + 32'd4;
        end
        if (bus.redirect_valid) begin
          q.delete();
          m_pc = bus.redirect_pc;
          if (m_out) m_killed = 1'b1;
        end
      end
    end
  end

  // Drives inputs for one cycle just after the edge, returns at the sample point.
  task automatic applyStimulus(input logic r, input logic st, input logic rv,
                               input logic [31:0] rpc);
    @(posedge clk);
    #1;
    rst                = r;
    bus.stall          = st;
    bus.redirect_valid = rv;
    bus.redirect_pc    = rpc;
    @(negedge clk);
  endtask

  task automatic do_reset(input bit check_values);
    for (int i = 0; i < 5; i++) applyStimulus(1'b1, 1'b0, 1'b0, 32'h0);
    if (check_values) begin
      checkOutput("rst_imem_req", bus.imem_req, 1'b0);
      checkOutput("rst_if_valid", bus.if_valid, 1'b0);
      checkOutput("rst_if_pc", bus.if_pc, 32'h0);
      checkOutput("rst_if_instr", bus.if_instr, 32'h0);
      checkOutput("rst_if_opcode", bus.if_opcode, 7'h00);
    end
  endtask

  initial begin
    rst                = 1'b1;
    bus.stall          = 1'b0;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc    = '0;

    $display("[TB] free-run, 1-cycle memory, constant R-type word");
    mem_const = 1'b1;
    mem_lat   = 1;
    do_reset(1'b1);
    for (int k = 0; k < 8; k++) begin
      applyStimulus(1'b0, 1'b0, 1'b0, 32'h0);
      if (k % 2 == 0) begin
        checkOutput("run_req", bus.imem_req, 1'b1);
        checkOutput("run_addr", bus.imem_addr, 32'(2 * k));
      end else begin
        checkOutput("run_req_idle", bus.imem_req, 1'b0);
      end
      if (k == 1) checkOutput("run_first_valid_late", bus.if_valid, 1'b0);
      if (k >= 2 && k % 2 == 0) begin
        checkOutput("run_valid", bus.if_valid, 1'b1);
        checkOutput("run_pc", bus.if_pc, 32'(2 * (k - 2)));
        checkOutput("run_opcode", bus.if_opcode, 7'b0110011);
        checkOutput("run_instr", bus.if_instr, 32'h0000_0033);
      end
    end

    $display("[TB] stall for 6 cycles after first valid");
    mem_const = 1'b0;
    do_reset(1'b0);
    for (int k = 0; k < 12; k++) begin
      applyStimulus(1'b0, (k >= 2 && k <= 7), 1'b0, 32'h0);
      if (k >= 2 && k <= 7) begin
        checkOutput("stall_valid", bus.if_valid, 1'b1);
        checkOutput("stall_pc_held", bus.if_pc, 32'h0);
      end
      if (k >= 4 && k <= 7) checkOutput("stall_no_req", bus.imem_req, 1'b0);
      if (k == 8) checkOutput("release_pc0", bus.if_pc, 32'h0);
      if (k == 9) begin
        checkOutput("release_valid4", bus.if_valid, 1'b1);
        checkOutput("release_pc4", bus.if_pc, 32'h4);
        checkOutput("release_instr4", bus.if_instr, 32'h0000_0233);
        checkOutput("resume_req", bus.imem_req, 1'b1);
        checkOutput("resume_addr", bus.imem_addr, 32'h8);
      end
      if (k == 10) checkOutput("resume_gap", bus.if_valid, 1'b0);
      if (k == 11) begin
        checkOutput("resume_pc8", bus.if_pc, 32'h8);
        checkOutput("resume_instr8", bus.if_instr, 32'h0000_0433);
      end
    end

    $display("[TB] redirect in WAIT, killed response 3 cycles later");
    mem_lat = 4;
    do_reset(1'b0);
    for (int k = 0; k < 11; k++) begin
      applyStimulus(1'b0, 1'b0, (k == 1), 32'h0000_0100);
      if (k == 0) checkOutput("drop_first_addr", bus.imem_addr, 32'h0);
      if (k >= 1 && k <= 4) checkOutput("drop_no_req", bus.imem_req, 1'b0);
      if (k == 5) begin
        checkOutput("drop_req_target", bus.imem_req, 1'b1);
        checkOutput("drop_addr_target", bus.imem_addr, 32'h0000_0100);
      end
      if (k >= 2 && k <= 9) checkOutput("drop_no_valid", bus.if_valid, 1'b0);
      if (k == 10) begin
        checkOutput("drop_target_valid", bus.if_valid, 1'b1);
        checkOutput("drop_target_pc", bus.if_pc, 32'h0000_0100);
        checkOutput("drop_target_instr", bus.if_instr, 32'h0000_8033);
      end
    end

    $display("[TB] redirect together with response in WAIT");
    mem_lat = 1;
    do_reset(1'b0);
    for (int k = 0; k < 5; k++) begin
      applyStimulus(1'b0, 1'b0, (k == 1), 32'h0000_0200);
      if (k == 2) begin
        checkOutput("same_req", bus.imem_req, 1'b1);
        checkOutput("same_addr", bus.imem_addr, 32'h0000_0200);
        checkOutput("same_dropped", bus.if_valid, 1'b0);
      end
      if (k == 3) checkOutput("same_dropped2", bus.if_valid, 1'b0);
      if (k == 4) begin
        checkOutput("same_pc", bus.if_pc, 32'h0000_0200);
        checkOutput("same_instr", bus.if_instr, 32'h0001_0033);
      end
    end

    $display("[TB] PC wrap at top of address space");
    do_reset(1'b0);
    for (int k = 0; k < 6; k++) begin
      applyStimulus(1'b0, 1'b0, (k == 1), 32'hFFFF_FFFC);
      if (k == 2) checkOutput("wrap_top_addr", bus.imem_addr, 32'hFFFF_FFFC);
      if (k == 4) begin
        checkOutput("wrap_req", bus.imem_req, 1'b1);
        checkOutput("wrap_addr", bus.imem_addr, 32'h0);
        checkOutput("wrap_pc", bus.if_pc, 32'hFFFF_FFFC);
        checkOutput("wrap_instr", bus.if_instr, 32'hFFFF_FE33);
      end
    end

    $display("[TB] reset while waiting, stale response during reset");
    mem_lat = 1;
    do_reset(1'b0);
    for (int k = 0; k < 13; k++) begin
      applyStimulus((k >= 5 && k <= 7), (k == 4), 1'b0, 32'h0);
      if (k == 3) mem_lat = 3;
      if (k == 4) begin
        checkOutput("mid_req8", bus.imem_addr, 32'h8);
        checkOutput("mid_pc4", bus.if_pc, 32'h4);
      end
      if (k == 5) checkOutput("mid_pre_reset_valid", bus.if_valid, 1'b1);
      if (k == 6 || k == 7) begin
        checkOutput("mid_rst_valid", bus.if_valid, 1'b0);
        checkOutput("mid_rst_req", bus.imem_req, 1'b0);
      end
      if (k == 8) begin
        checkOutput("mid_after_req", bus.imem_req, 1'b1);
        checkOutput("mid_after_addr", bus.imem_addr, 32'h0);
        checkOutput("mid_after_valid", bus.if_valid, 1'b0);
        checkOutput("mid_after_pc", bus.if_pc, 32'h0);
        checkOutput("mid_after_instr", bus.if_instr, 32'h0);
        checkOutput("mid_after_opcode", bus.if_opcode, 7'h00);
      end
      if (k >= 9 && k <= 11) checkOutput("mid_stale_ignored", bus.if_valid, 1'b0);
      if (k == 12) begin
        checkOutput("mid_fresh_valid", bus.if_valid, 1'b1);
        checkOutput("mid_fresh_pc", bus.if_pc, 32'h0);
        checkOutput("mid_fresh_instr", bus.if_instr, 32'h0000_0033);
      end
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL timeout: simulation did not finish, checks=%0d", checks);
    $fatal(1, "[TB] timeout");
  end

endmodule
